// File: rtl/htu_pipe_gen_if.sv
// Request, tag-array, lookup, issue and memory signal bundle for the hit-test pipeline.
// The master modport is the pipeline's view; slave is the surrounding array/issue logic.
interface htu_pipe_gen_if #(
    parameter int WAYS   = 8,
    parameter int SETS   = 8,
    parameter int TAG_W  = 20,
    parameter int OFF_W  = 4,
    parameter int REF_W  = 3,
    parameter int CH_W   = 3,
    parameter int WBUF_W = 7
);
    localparam int WAY_W = $clog2(WAYS);
    localparam int SET_W = $clog2(SETS);

    logic                     req_valid;
    logic                     req_ready;
    logic [31:0]              req_addr;
    logic                     req_op;
    logic [CH_W-1:0]          req_ch;
    logic [WBUF_W-1:0]        req_wbuf;

    logic                     rd_valid;
    logic                     rd_ready;
    logic [SET_W-1:0]         rd_set;
    logic [WAYS*TAG_W-1:0]    rd_tag;
    logic [WAYS*2-1:0]        rd_meta;

    logic                     wr_valid;
    logic                     wr_ready;
    logic [SET_W-1:0]         wr_set;
    logic [WAYS-1:0]          wr_way_en;
    logic [TAG_W-1:0]         wr_tag;
    logic [1:0]               wr_meta;

    logic [SET_W-1:0]         ref_set;
    logic [WAYS*REF_W-1:0]    ref_cnt;
    logic [SET_W-1:0]         repl_set;
    logic [WAY_W-1:0]         repl_way;

    logic                     upd_valid;
    logic [SET_W-1:0]         upd_set;
    logic [WAY_W-1:0]         upd_way;

    logic                     isu_valid;
    logic                     isu_ready;
    logic [2:0]               isu_op;
    logic [CH_W-1:0]          isu_ch;
    logic [WAY_W+SET_W-1:0]   isu_id;
    logic [OFF_W-1:0]         isu_offset;
    logic [WBUF_W-1:0]        isu_wbuf;
    logic                     isu_refill;

    logic                     mem_valid;
    logic                     mem_ready;
    logic                     mem_op;
    logic [WAY_W+SET_W-1:0]   mem_id;
    logic [31:0]              mem_addr;

    modport master (
        input  req_valid, req_addr, req_op, req_ch, req_wbuf, output req_ready,
        output rd_valid, rd_set, input rd_ready, rd_tag, rd_meta,
        output wr_valid, wr_set, wr_way_en, wr_tag, wr_meta, input wr_ready,
        output ref_set, repl_set, input ref_cnt, repl_way,
        output upd_valid, upd_set, upd_way,
        output isu_valid, isu_op, isu_ch, isu_id, isu_offset, isu_wbuf, isu_refill, input isu_ready,
        output mem_valid, mem_op, mem_id, mem_addr, input mem_ready
    );

    modport slave (
        output req_valid, req_addr, req_op, req_ch, req_wbuf, input req_ready,
        input  rd_valid, rd_set, output rd_ready, rd_tag, rd_meta,
        input  wr_valid, wr_set, wr_way_en, wr_tag, wr_meta, output wr_ready,
        input  ref_set, repl_set, output ref_cnt, repl_way,
        input  upd_valid, upd_set, upd_way,
        input  isu_valid, isu_op, isu_ch, isu_id, isu_offset, isu_wbuf, isu_refill, output isu_ready,
        input  mem_valid, mem_op, mem_id, mem_addr, output mem_ready
    );
endinterface

// File: rtl/htu_pipe_gen.sv
// Three-stage tag lookup / way select / commit pipeline; commits two cycles after accept, one request per cycle.
// Stalls upstream when s2 is blocked on ref counts or any downstream ready is low; all outputs fire atomically.
module htu_pipe_gen #(
    parameter int WAYS     = 8,
    parameter int SETS     = 8,
    parameter int TAG_W    = 20,
    parameter int OFF_W    = 4,
    parameter int BYTE_W   = 3,
    parameter int REF_W    = 3,
    parameter int CH_W     = 3,
    parameter int WBUF_W   = 7,
    parameter bit WR_ALLOC = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    htu_pipe_gen_if.master bus
);
    localparam int WAY_W   = $clog2(WAYS);
    localparam int SET_W   = $clog2(SETS);
    localparam int SET_LSB = OFF_W + BYTE_W;

    localparam logic [1:0] META_INV    = 2'd0;
    localparam logic [1:0] META_SHARE  = 2'd1;
    localparam logic [1:0] META_UNIQUE = 2'd2;
    localparam logic [2:0] OP_LOAD  = 3'd0;
    localparam logic [2:0] OP_STORE = 3'd1;
    localparam logic [2:0] OP_RAE   = 3'd2;
    localparam logic [2:0] OP_WAE   = 3'd3;
    localparam logic [2:0] OP_WNA   = 3'd4;

    logic accept, s1_ready, s1_adv, s2_fire;
    logic [SET_W-1:0] req_set;

    assign req_set       = bus.req_addr[SET_LSB +: SET_W];
    assign bus.req_ready = !rst && bus.rd_ready && s1_ready;
    assign accept        = bus.req_ready && bus.req_valid;
    assign bus.rd_valid  = accept;
    assign bus.rd_set    = accept ? req_set : '0;

    logic                               s1_valid, s1_new, s1_op;
    logic [31:0]                        s1_addr;
    logic [CH_W-1:0]                    s1_ch;
    logic [WBUF_W-1:0]                  s1_wbuf;
    logic [WAYS-1:0][TAG_W-1:0]         s1_tag_q, eff_tag;
    logic [WAYS-1:0][1:0]               s1_meta_q, eff_meta;
    logic [WAYS-1:0]                    pend_en;
    logic [TAG_W-1:0]                   pend_tag;
    logic [1:0]                         pend_meta;
    logic                               s1_hit, s1_inv, wr_s1;
    logic [WAY_W-1:0]                   s1_hway, s1_iway;

    logic                               s2_valid, s2_op, s2_hit, s2_inv;
    logic [31:0]                        s2_addr;
    logic [CH_W-1:0]                    s2_ch;
    logic [WBUF_W-1:0]                  s2_wbuf;
    logic [WAY_W-1:0]                   s2_hway, s2_iway;
    logic [WAYS-1:0][1:0]               s2_meta;

    assign s1_adv   = s1_valid && (!s2_valid || s2_fire);
    assign s1_ready = !s1_valid || s1_adv;
    assign wr_s1    = bus.wr_valid && (bus.wr_set == s1_addr[SET_LSB +: SET_W]);

    // Held array view, patched by writes that landed after the array was sampled.
    always_comb begin
        eff_tag  = s1_tag_q;
        eff_meta = s1_meta_q;
        s1_hit   = 1'b0;
        s1_hway  = '0;
        s1_inv   = 1'b0;
        s1_iway  = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (s1_new) begin
                eff_tag[i]  = bus.rd_tag[i*TAG_W +: TAG_W];
                eff_meta[i] = bus.rd_meta[i*2 +: 2];
                if (pend_en[i]) begin
                    eff_tag[i]  = pend_tag;
                    eff_meta[i] = pend_meta;
                end
            end
            if (wr_s1 && bus.wr_way_en[i]) begin
                eff_tag[i]  = bus.wr_tag;
                eff_meta[i] = bus.wr_meta;
            end
            if (eff_tag[i] == s1_addr[31 -: TAG_W] && eff_meta[i] != META_INV) begin
                s1_hit  = 1'b1;
                s1_hway = WAY_W'(i);
            end
        end
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (eff_meta[i] == META_INV) begin
                s1_inv  = 1'b1;
                s1_iway = WAY_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_new    <= 1'b0;
            s1_op     <= 1'b0;
            s1_addr   <= '0;
            s1_ch     <= '0;
            s1_wbuf   <= '0;
            s1_tag_q  <= '0;
            s1_meta_q <= '0;
            pend_en   <= '0;
            pend_tag  <= '0;
            pend_meta <= '0;
        end else begin
            s1_new    <= accept;
            s1_tag_q  <= eff_tag;
            s1_meta_q <= eff_meta;
            if (accept) begin
                s1_valid  <= 1'b1;
                s1_op     <= bus.req_op;
                s1_addr   <= bus.req_addr;
                s1_ch     <= bus.req_ch;
                s1_wbuf   <= bus.req_wbuf;
                pend_en   <= (bus.wr_valid && bus.wr_set == req_set) ? bus.wr_way_en : '0;
                pend_tag  <= bus.wr_tag;
                pend_meta <= bus.wr_meta;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_op    <= 1'b0;
            s2_addr  <= '0;
            s2_ch    <= '0;
            s2_wbuf  <= '0;
            s2_hit   <= 1'b0;
            s2_hway  <= '0;
            s2_inv   <= 1'b0;
            s2_iway  <= '0;
            s2_meta  <= '0;
        end else if (s1_adv) begin
            s2_valid <= 1'b1;
            s2_op    <= s1_op;
            s2_addr  <= s1_addr;
            s2_ch    <= s1_ch;
            s2_wbuf  <= s1_wbuf;
            s2_hit   <= s1_hit;
            s2_hway  <= s1_hway;
            s2_inv   <= s1_inv;
            s2_iway  <= s1_iway;
            s2_meta  <= eff_meta;
        end else if (s2_fire) begin
            s2_valid <= 1'b0;
        end
    end

    logic [SET_W-1:0] s2_set;
    logic [WAY_W-1:0] victim, way;
    logic [REF_W-1:0] sel_ref;
    logic             wna, alloc, blocked, need_mem;
    logic [2:0]       isu_op_c;

    assign s2_set       = s2_addr[SET_LSB +: SET_W];
    assign bus.ref_set  = s2_set;
    assign bus.repl_set = s2_set;

    always_comb begin
        victim   = s2_inv ? s2_iway : bus.repl_way;
        way      = s2_hit ? s2_hway : victim;
        wna      = !s2_hit && s2_op && !WR_ALLOC;
        alloc    = !s2_hit && !wna;
        sel_ref  = bus.ref_cnt[int'(way)*REF_W +: REF_W];
        // A saturated ref pins the line; an eviction must also wait for the victim to drain.
        blocked  = !wna && ((&sel_ref) || (alloc && sel_ref != '0));
        need_mem = !s2_hit;
        s2_fire  = s2_valid && !blocked && bus.isu_ready && bus.wr_ready &&
                   (bus.mem_ready || !need_mem);
        if (s2_hit)                             isu_op_c = s2_op ? OP_STORE : OP_LOAD;
        else if (wna)                           isu_op_c = OP_WNA;
        else if (s2_meta[victim] == META_UNIQUE) isu_op_c = s2_op ? OP_WAE : OP_RAE;
        else                                    isu_op_c = s2_op ? OP_STORE : OP_LOAD;
    end

    always_comb begin
        bus.isu_valid  = 1'b0;
        bus.isu_op     = '0;
        bus.isu_ch     = '0;
        bus.isu_id     = '0;
        bus.isu_offset = '0;
        bus.isu_wbuf   = '0;
        bus.isu_refill = 1'b0;
        bus.wr_valid   = 1'b0;
        bus.wr_set     = '0;
        bus.wr_way_en  = '0;
        bus.wr_tag     = '0;
        bus.wr_meta    = '0;
        bus.mem_valid  = 1'b0;
        bus.mem_op     = 1'b0;
        bus.mem_id     = '0;
        bus.mem_addr   = '0;
        bus.upd_valid  = 1'b0;
        bus.upd_set    = '0;
        bus.upd_way    = '0;
        if (s2_fire) begin
            bus.isu_valid  = 1'b1;
            bus.isu_op     = isu_op_c;
            bus.isu_ch     = s2_ch;
            bus.isu_id     = {way, s2_set};
            bus.isu_offset = s2_addr[BYTE_W +: OFF_W];
            bus.isu_wbuf   = s2_wbuf;
            bus.isu_refill = alloc;
            bus.wr_valid   = alloc || (s2_hit && s2_op);
            bus.wr_set     = s2_set;
            bus.wr_way_en  = WAYS'(1) << way;
            bus.wr_tag     = s2_addr[31 -: TAG_W];
            bus.wr_meta    = s2_op ? META_UNIQUE : META_SHARE;
            bus.mem_valid  = need_mem;
            bus.mem_op     = wna;
            bus.mem_id     = {way, s2_set};
            bus.mem_addr   = s2_addr;
            bus.upd_valid  = !wna;
            bus.upd_set    = s2_set;
            bus.upd_way    = way;
        end
    end
endmodule

// File: tb/tb_htu_pipe_gen.sv
// Directed bench: tag-array model around two pipelines (write-allocate and write-no-allocate).
module tb_htu_pipe_gen;
    localparam int WAYS = 8, SETS = 8, TAG_W = 23, OFF_W = 3, BYTE_W = 3;
    localparam int REF_W = 3, CH_W = 3, WBUF_W = 7, WAY_W = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    htu_pipe_gen_if #(.WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W), .OFF_W(OFF_W), .REF_W(REF_W),
                      .CH_W(CH_W), .WBUF_W(WBUF_W)) bus ();
    htu_pipe_gen_if #(.WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W), .OFF_W(OFF_W), .REF_W(REF_W),
                      .CH_W(CH_W), .WBUF_W(WBUF_W)) bus1 ();

    htu_pipe_gen #(.WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W), .OFF_W(OFF_W), .BYTE_W(BYTE_W),
                   .REF_W(REF_W), .CH_W(CH_W), .WBUF_W(WBUF_W), .WR_ALLOC(1'b1))
        dut (.clk(clk), .rst(rst), .bus(bus));
    htu_pipe_gen #(.WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W), .OFF_W(OFF_W), .BYTE_W(BYTE_W),
                   .REF_W(REF_W), .CH_W(CH_W), .WBUF_W(WBUF_W), .WR_ALLOC(1'b0))
        dut_wna (.clk(clk), .rst(rst), .bus(bus1));

    logic [TAG_W-1:0] tmem [SETS][WAYS];
    logic [1:0]       mmem [SETS][WAYS];
    logic [REF_W-1:0] refs [SETS][WAYS];
    logic [WAY_W-1:0] repl_v;
    int               fires = 0;
    int               n_err = 0;
    int               n_chk = 0;

    // Read-first array model; set 4 is preloaded full with way 5 UNIQUE.
    always @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++) begin
                    tmem[s][w] <= (s == 4) ? TAG_W'(32'h111 + w) : '0;
                    mmem[s][w] <= (s == 4) ? ((w == 5) ? 2'd2 : 2'd1) : 2'd0;
                end
        end else begin
            if (bus.rd_valid)
                for (int w = 0; w < WAYS; w++) begin
                    bus.rd_tag[w*TAG_W +: TAG_W] <= tmem[bus.rd_set][w];
                    bus.rd_meta[w*2 +: 2]        <= mmem[bus.rd_set][w];
                end
            if (bus.wr_valid && bus.wr_ready)
                for (int w = 0; w < WAYS; w++)
                    if (bus.wr_way_en[w]) begin
                        tmem[bus.wr_set][w] <= bus.wr_tag;
                        mmem[bus.wr_set][w] <= bus.wr_meta;
                    end
        end
        if (bus.isu_valid && bus.isu_ready) fires <= fires + 1;
    end

    always_comb begin
        bus.ref_cnt = '0;
        for (int w = 0; w < WAYS; w++) bus.ref_cnt[w*REF_W +: REF_W] = refs[bus.ref_set][w];
    end
    assign bus.repl_way  = repl_v;
    assign bus1.rd_tag   = '0;
    assign bus1.rd_meta  = '0;
    assign bus1.ref_cnt  = '0;
    assign bus1.repl_way = '0;

    task automatic chk(input string tag, input logic ok);
        n_chk++;
        if (ok !== 1'b1) begin
            n_err++;
            $display("FAIL %s", tag);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic op, input logic [CH_W-1:0] ch,
                         input logic [WBUF_W-1:0] wb);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_op    = op;
        bus.req_ch    = ch;
        bus.req_wbuf  = wb;
    endtask

    // Present one request for a single cycle and return at the negedge of its commit cycle.
    task automatic send(input logic [31:0] a, input logic op);
        drive(a, op, 3'b001, 7'd5);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        bus.req_valid = 1'b1; bus.req_addr = '0; bus.req_op = 1'b0; bus.req_ch = '0; bus.req_wbuf = '0;
        bus.rd_ready = 1'b1; bus.wr_ready = 1'b1; bus.isu_ready = 1'b1; bus.mem_ready = 1'b1;
        bus1.req_valid = 1'b0; bus1.req_addr = '0; bus1.req_op = 1'b0; bus1.req_ch = '0; bus1.req_wbuf = '0;
        bus1.rd_ready = 1'b1; bus1.wr_ready = 1'b1; bus1.isu_ready = 1'b1; bus1.mem_ready = 1'b1;
        repl_v = '0;
        for (int s = 0; s < SETS; s++) for (int w = 0; w < WAYS; w++) refs[s][w] = '0;

        repeat (3) @(negedge clk);
        chk("rst_req_ready", bus.req_ready === 1'b0);
        chk("rst_rd_valid", bus.rd_valid === 1'b0);
        chk("rst_isu_valid", bus.isu_valid === 1'b0);
        chk("rst_wr_valid", bus.wr_valid === 1'b0);
        chk("rst_mem_valid", bus.mem_valid === 1'b0);
        chk("rst_upd_valid", bus.upd_valid === 1'b0);
        chk("rst_isu_op", bus.isu_op === 3'd0);
        bus.req_valid = 1'b0;
        rst = 1'b0;
        #1 chk("post_rst_ready", bus.req_ready === 1'b1);

        // Fill into empty set 1
        @(negedge clk);
        drive(32'h1000_0040, 1'b0, 3'b001, 7'd5);
        #1;
        chk("fill_rd_valid", bus.rd_valid === 1'b1);
        chk("fill_rd_set", bus.rd_set === 3'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("fill_no_early", bus.isu_valid === 1'b0);
        @(negedge clk);
        chk("fill_isu_valid", bus.isu_valid === 1'b1);
        chk("fill_isu_op", bus.isu_op === 3'd0);
        chk("fill_refill", bus.isu_refill === 1'b1);
        chk("fill_isu_id", bus.isu_id === 6'h01);
        chk("fill_isu_ch", bus.isu_ch === 3'b001);
        chk("fill_isu_wbuf", bus.isu_wbuf === 7'd5);
        chk("fill_wr_valid", bus.wr_valid === 1'b1);
        chk("fill_wr_way_en", bus.wr_way_en === 8'h01);
        chk("fill_wr_meta", bus.wr_meta === 2'd1);
        chk("fill_wr_tag", bus.wr_tag === 23'h08_0000);
        chk("fill_mem_valid", bus.mem_valid === 1'b1);
        chk("fill_mem_op", bus.mem_op === 1'b0);
        chk("fill_mem_addr", bus.mem_addr === 32'h1000_0040);
        chk("fill_mem_id", bus.mem_id === 6'h01);
        chk("fill_upd_valid", bus.upd_valid === 1'b1);
        chk("fill_upd_set", bus.upd_set === 3'd1);

        // Back-to-back same line, set 2
        @(negedge clk);
        drive(32'h2000_0080, 1'b0, 3'b001, 7'd1);
        #1 chk("b2b_ready0", bus.req_ready === 1'b1);
        @(negedge clk);
        drive(32'h2000_0088, 1'b0, 3'b010, 7'd9);
        #1 chk("b2b_ready1", bus.req_ready === 1'b1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("b2b_a_valid", bus.isu_valid === 1'b1);
        chk("b2b_a_refill", bus.isu_refill === 1'b1);
        chk("b2b_a_way_en", bus.wr_way_en === 8'h01);
        @(negedge clk);
        chk("b2b_b_valid", bus.isu_valid === 1'b1);
        chk("b2b_b_op", bus.isu_op === 3'd0);
        chk("b2b_b_refill", bus.isu_refill === 1'b0);
        chk("b2b_b_wr_valid", bus.wr_valid === 1'b0);
        chk("b2b_b_mem_valid", bus.mem_valid === 1'b0);
        chk("b2b_b_id", bus.isu_id === 6'h02);
        chk("b2b_b_offset", bus.isu_offset === 3'd1);
        chk("b2b_b_ch", bus.isu_ch === 3'b010);

        // Same line accepted in the cycle the first one writes, set 5
        @(negedge clk);
        drive(32'h3000_0140, 1'b0, 3'b001, 7'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        drive(32'h3000_0150, 1'b0, 3'b001, 7'd2);
        chk("rdw_a_refill", bus.isu_refill === 1'b1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("rdw_b_valid", bus.isu_valid === 1'b1);
        chk("rdw_b_refill", bus.isu_refill === 1'b0);
        chk("rdw_b_id", bus.isu_id === 6'h05);
        chk("rdw_b_offset", bus.isu_offset === 3'd2);

        // Ref back-pressure on the set-1 line
        refs[1][0] = 3'd7;
        @(negedge clk);
        drive(32'h1000_0048, 1'b0, 3'b001, 7'd3);
        @(negedge clk);
        drive(32'h3000_00C0, 1'b0, 3'b001, 7'd4);
        #1 chk("ref_ready_n1", bus.req_ready === 1'b1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        #1;
        chk("ref_blocked_n2", bus.isu_valid === 1'b0);
        chk("ref_req_ready_n2", bus.req_ready === 1'b0);
        chk("ref_set_n2", bus.ref_set === 3'd1);
        @(negedge clk);
        chk("ref_blocked_n3", bus.isu_valid === 1'b0);
        refs[1][0] = 3'd6;
        #1;
        chk("ref_release_valid", bus.isu_valid === 1'b1);
        chk("ref_release_refill", bus.isu_refill === 1'b0);
        chk("ref_release_id", bus.isu_id === 6'h01);
        chk("ref_release_off", bus.isu_offset === 3'd1);
        @(negedge clk);
        refs[1][0] = 3'd0;
        chk("ref_next_valid", bus.isu_valid === 1'b1);
        chk("ref_next_id", bus.isu_id === 6'h03);
        chk("ref_next_refill", bus.isu_refill === 1'b1);

        // Dirty eviction, store hit and load eviction in full set 4
        repl_v = 3'd5;
        @(negedge clk);
        send(32'h5000_0100, 1'b1);
        chk("evict_valid", bus.isu_valid === 1'b1);
        chk("evict_op", bus.isu_op === 3'd3);
        chk("evict_way_en", bus.wr_way_en === 8'h20);
        chk("evict_meta", bus.wr_meta === 2'd2);
        chk("evict_tag", bus.wr_tag === 23'h28_0000);
        chk("evict_mem_op", bus.mem_op === 1'b0);
        chk("evict_refill", bus.isu_refill === 1'b1);
        chk("evict_id", bus.isu_id === 6'h2C);
        @(negedge clk);
        send(32'h0002_2700, 1'b1);
        chk("sthit_op", bus.isu_op === 3'd1);
        chk("sthit_way_en", bus.wr_way_en === 8'h04);
        chk("sthit_meta", bus.wr_meta === 2'd2);
        chk("sthit_tag", bus.wr_tag === 23'h113);
        chk("sthit_mem_valid", bus.mem_valid === 1'b0);
        chk("sthit_refill", bus.isu_refill === 1'b0);
        @(negedge clk);
        send(32'h6000_0100, 1'b0);
        chk("rae_op", bus.isu_op === 3'd2);
        chk("rae_meta", bus.wr_meta === 2'd1);
        chk("rae_way_en", bus.wr_way_en === 8'h20);

        // Write-no-allocate store miss
        @(negedge clk);
        bus1.req_valid = 1'b1; bus1.req_addr = 32'h0000_0008; bus1.req_op = 1'b1;
        @(negedge clk);
        bus1.req_valid = 1'b0;
        @(negedge clk);
        chk("wna_isu_valid", bus1.isu_valid === 1'b1);
        chk("wna_isu_op", bus1.isu_op === 3'd4);
        chk("wna_mem_valid", bus1.mem_valid === 1'b1);
        chk("wna_mem_op", bus1.mem_op === 1'b1);
        chk("wna_wr_valid", bus1.wr_valid === 1'b0);
        chk("wna_upd_valid", bus1.upd_valid === 1'b0);
        chk("wna_refill", bus1.isu_refill === 1'b0);

        // Reset pulse with s1 and s2 occupied
        bus.isu_ready = 1'b0;
        @(negedge clk);
        drive(32'h7000_0000, 1'b0, 3'b001, 7'd1);
        @(negedge clk);
        drive(32'h7000_0040, 1'b0, 3'b001, 7'd2);
        @(negedge clk);
        bus.req_valid = 1'b0;
        #1 chk("full_req_ready", bus.req_ready === 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_isu_valid", bus.isu_valid === 1'b0);
        chk("midrst_req_ready", bus.req_ready === 1'b0);
        chk("midrst_wr_valid", bus.wr_valid === 1'b0);
        chk("midrst_mem_valid", bus.mem_valid === 1'b0);
        bus.isu_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        begin
            int f0;
            f0 = fires;
            #1 chk("midrst_first_ready", bus.req_ready === 1'b1);
            repeat (4) @(negedge clk);
            chk("midrst_no_commit", (fires - f0) === 0);
            chk("midrst_idle_valid", bus.isu_valid === 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
